// File: rtl/noc_pkt_receiver.sv
// NoC ejection endpoint: flit FIFO, header/size/payload parser, payload stream.
// Optional PKT_TIMESTAMP_EN adds arrival/completion cycle stamps.
module noc_pkt_receiver #(
  parameter int FLIT_SIZE    = 32,
  parameter int BUFFER_DEPTH = 8,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 rx_i,
  output logic                 credit_o,
  input  logic [FLIT_SIZE-1:0] data_i,
  output logic [FLIT_SIZE-1:0] hdr_o,
  output logic [FLIT_SIZE-1:0] size_o,
  output logic                 hdr_valid_o,
  output logic [FLIT_SIZE-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 last_o,
  output logic                 pkt_done_o,
  output logic [CNT_WIDTH-1:0] pkt_cnt_o,
`ifdef PKT_TIMESTAMP_EN
  output logic [CNT_WIDTH-1:0] ts_hdr_o,
  output logic [CNT_WIDTH-1:0] ts_done_o,
`endif
  output logic                 overflow_o
);

  localparam int AW = $clog2(BUFFER_DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(BUFFER_DEPTH);
  localparam logic [FLIT_SIZE-1:0] ONE = FLIT_SIZE'(1);

  typedef enum logic [1:0] {
    S_HEADER,
    S_SIZE,
    S_PAYLOAD,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [FLIT_SIZE-1:0] mem [BUFFER_DEPTH];
  logic [AW:0]          wr_ptr_q, rd_ptr_q;
  logic [AW:0]          wr_ptr_d, rd_ptr_d;
  logic [AW:0]          count_d;
  logic                 empty;
  logic                 push, pop;
  logic [FLIT_SIZE-1:0] head;
  logic                 credit_q;

  logic [FLIT_SIZE-1:0] hdr_q, size_q, rem_q;
  logic                 hdr_valid_q;
  logic [CNT_WIDTH-1:0] pkt_cnt_q;
  logic                 overflow_q;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign head  = mem[rd_ptr_q[AW-1:0]];
  assign push  = rx_i && credit_q;

  assign wr_ptr_d = wr_ptr_q + (AW+1)'(push);
  assign rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
  assign count_d  = wr_ptr_d - rd_ptr_d;

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_q[AW-1:0]] <= data_i;
  end

  // credit is a register of next occupancy, so ready_i never reaches it combinationally
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      credit_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      credit_q <= (count_d != DEPTH_L);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_HEADER;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_HEADER:  if (!empty) state_d = S_SIZE;
      S_SIZE:    if (!empty) state_d = (head == '0) ? S_DONE : S_PAYLOAD;
      S_PAYLOAD: if (!empty && ready_i && rem_q == ONE) state_d = S_DONE;
      S_DONE:    state_d = S_HEADER;
      default:   state_d = S_HEADER;
    endcase
  end

  always_comb begin
    pop        = 1'b0;
    valid_o    = 1'b0;
    last_o     = 1'b0;
    pkt_done_o = 1'b0;
    data_o     = '0;
    unique case (1'b1)
      (state_q == S_HEADER),
      (state_q == S_SIZE): pop = !empty;
      (state_q == S_PAYLOAD): begin
        valid_o = !empty;
        data_o  = empty ? '0 : head;
        last_o  = !empty && (rem_q == ONE);
        pop     = !empty && ready_i;
      end
      (state_q == S_DONE): pkt_done_o = 1'b1;
      default: pop = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hdr_q       <= '0;
      size_q      <= '0;
      rem_q       <= '0;
      hdr_valid_q <= 1'b0;
      pkt_cnt_q   <= '0;
      overflow_q  <= 1'b0;
    end else begin
      if (state_q == S_HEADER && !empty) hdr_q <= head;
      if (state_q == S_SIZE && !empty) begin
        size_q      <= head;
        rem_q       <= head;
        hdr_valid_q <= 1'b1;
      end
      if (state_q == S_PAYLOAD && pop) rem_q <= rem_q - ONE;
      if (state_q == S_DONE) begin
        hdr_valid_q <= 1'b0;
        pkt_cnt_q   <= pkt_cnt_q + CNT_WIDTH'(1);
      end
      if (rx_i && !credit_q) overflow_q <= 1'b1;
    end
  end

  assign credit_o    = credit_q;
  assign hdr_o       = hdr_q;
  assign size_o      = size_q;
  assign hdr_valid_o = hdr_valid_q;
  assign pkt_cnt_o   = pkt_cnt_q;
  assign overflow_o  = overflow_q;

`ifdef PKT_TIMESTAMP_EN
  typedef enum logic [1:0] {
    W_HDR,
    W_SIZE,
    W_PAY
  } wph_t;

  wph_t                 wph_q;
  logic [FLIT_SIZE-1:0] wrem_q;
  logic [CNT_WIDTH-1:0] cyc_q;
  logic [CNT_WIDTH-1:0] ts_mem [BUFFER_DEPTH];
  logic [AW:0]          ts_wr_q, ts_rd_q;
  logic [CNT_WIDTH-1:0] ts_hdr_q;
  logic                 ts_push, ts_pop;

  // write-side framing tracker spots header flits as they enter the FIFO
  assign ts_push = push && (wph_q == W_HDR);
  assign ts_pop  = (state_q == S_HEADER) && !empty;

  always_ff @(posedge clk_i) begin
    if (ts_push) ts_mem[ts_wr_q[AW-1:0]] <= cyc_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wph_q    <= W_HDR;
      wrem_q   <= '0;
      cyc_q    <= '0;
      ts_wr_q  <= '0;
      ts_rd_q  <= '0;
      ts_hdr_q <= '0;
    end else begin
      cyc_q <= cyc_q + CNT_WIDTH'(1);
      if (ts_push) ts_wr_q <= ts_wr_q + (AW+1)'(1);
      if (ts_pop) begin
        ts_hdr_q <= ts_mem[ts_rd_q[AW-1:0]];
        ts_rd_q  <= ts_rd_q + (AW+1)'(1);
      end
      if (push) begin
        unique case (wph_q)
          W_HDR:  wph_q <= W_SIZE;
          W_SIZE: begin
            wrem_q <= data_i;
            wph_q  <= (data_i == '0) ? W_HDR : W_PAY;
          end
          W_PAY: begin
            wrem_q <= wrem_q - ONE;
            if (wrem_q == ONE) wph_q <= W_HDR;
          end
          default: wph_q <= W_HDR;
        endcase
      end
    end
  end

  assign ts_hdr_o  = ts_hdr_q;
  assign ts_done_o = (state_q == S_DONE) ? cyc_q : '0;
`endif

endmodule
